// File: rtl/road_scroller.sv
// road_scroller: lane-marker animation engine for the racing display.
//
// Draws NUM_LANES vertical dashed lines over the track colour and scrolls them
// downward at a level-dependent speed. Speed steps accumulate in a small
// pending counter and are folded into the scroll offset only on frame_start,
// so a frame never shows a half-updated road.
//
// Ports:
//   clk          in   system clock
//   reset_n      in   synchronous active-low reset
//   pix_row      in   current pixel row from the display timing generator
//   pix_col      in   current pixel column from the display timing generator
//   level        in   game level, selects the step divisor
//   enable       in   scroll enable (0 = paused)
//   frame_start  in   one-cycle pulse at start of vertical blank
//   track_color  in   background colour for the current pixel
//   road_out     out  registered road pixel colour (1-cycle latency)
//   offset       out  current scroll offset, 0..PERIOD-1
//   step_pulse   out  one-cycle pulse on each speed step
module road_scroller #(
    parameter int          CLK_HZ     = 100000000,
    parameter int          BASE_HZ    = 500,
    parameter int          DASH_LEN   = 48,
    parameter int          DASH_GAP   = 48,
    parameter int          STEP       = 8,
    parameter int          NUM_LANES  = 2,
    parameter int          LANE_X0    = 255,
    parameter int          LANE_PITCH = 128,
    parameter int          LINE_W     = 4,
    parameter int          DIV0       = 6,
    parameter int          DIV1       = 4,
    parameter int          DIV2       = 2,
    parameter int          DIV3       = 1,
    parameter logic [11:0] LINE_COLOR = 12'hFFF,
    localparam int         PERIOD     = DASH_LEN + DASH_GAP,
    localparam int         OFF_W      = $clog2(PERIOD)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [9:0]       pix_row,
    input  logic [9:0]       pix_col,
    input  logic [1:0]       level,
    input  logic             enable,
    input  logic             frame_start,
    input  logic [11:0]      track_color,
    output logic [11:0]      road_out,
    output logic [OFF_W-1:0] offset,
    output logic             step_pulse
);

    localparam int PRESC   = CLK_HZ / BASE_HZ;
    localparam int PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int DIV_W   = 8;
    localparam int SUM_W   = OFF_W + 1;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0]   div_sel;
    logic [1:0]         level_q;
    logic               step_q, step_d;
    logic [3:0]         pend_q, pend_d;
    logic [3:0]         apply_cnt;
    logic [OFF_W-1:0]   offset_q, offset_d;
    logic [OFF_W-1:0]   off_acc;
    logic [SUM_W-1:0]   off_sum;
    logic [11:0]        road_q, road_d;
    logic               tick;
    logic               level_chg;

    // Prescaler: free-running, keeps counting while paused.
    assign tick = (presc_q == PRESC_W'(PRESC - 1));

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    always_comb begin
        case (level)
            2'd0:    div_sel = DIV_W'(DIV0);
            2'd1:    div_sel = DIV_W'(DIV1);
            2'd2:    div_sel = DIV_W'(DIV2);
            default: div_sel = DIV_W'(DIV3);
        endcase
    end

    assign level_chg = (level != level_q);

    // Divider: one step per (div+1) ticks. A level change restarts the count so
    // the new speed takes effect from a clean phase.
    always_comb begin
        div_cnt_d = div_cnt_q;
        step_d    = 1'b0;
        if (level_chg || !enable) begin
            div_cnt_d = '0;
        end else if (tick) begin
            if (div_cnt_q == div_sel) begin
                div_cnt_d = '0;
                step_d    = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    // Step count as it would stand after this cycle, saturating at 15. This is
    // also what a coincident frame_start applies, so a step arriving on the
    // frame_start cycle is not lost.
    always_comb begin
        apply_cnt = '0;
        if (enable) begin
            if (step_q && (pend_q != 4'd15)) begin
                apply_cnt = pend_q + 4'd1;
            end else begin
                apply_cnt = pend_q;
            end
        end
    end

    always_comb begin
        pend_d = frame_start ? 4'd0 : apply_cnt;
    end

    // Offset advance as a chain of conditional add-and-wrap stages; each stage
    // stays below 2*PERIOD because STEP < PERIOD, so no divider is needed.
    always_comb begin
        off_acc = offset_q;
        off_sum = '0;
        for (int i = 0; i < 15; i++) begin
            if (i < int'(apply_cnt)) begin
                off_sum = {1'b0, off_acc} + SUM_W'(STEP);
                if (off_sum >= SUM_W'(PERIOD)) begin
                    off_sum = off_sum - SUM_W'(PERIOD);
                end
                off_acc = off_sum[OFF_W-1:0];
            end
        end
        offset_d = frame_start ? off_acc : offset_q;
    end

    // Pixel path: row relative to the scrolled dash pattern, then lane columns.
    logic [OFF_W-1:0] row_mod;
    logic [SUM_W-1:0] row_rel;
    logic             row_hit;
    logic             col_hit;

    always_comb begin
        row_mod = OFF_W'(int'(pix_row) % PERIOD);
        if (row_mod >= offset_q) begin
            row_rel = {1'b0, row_mod} - {1'b0, offset_q};
        end else begin
            row_rel = {1'b0, row_mod} + SUM_W'(PERIOD) - {1'b0, offset_q};
        end
        row_hit = (row_rel < SUM_W'(DASH_LEN));
    end

    always_comb begin
        col_hit = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if ((int'(pix_col) >= LANE_X0 + i * LANE_PITCH) &&
                (int'(pix_col) <= LANE_X0 + i * LANE_PITCH + LINE_W - 1)) begin
                col_hit = 1'b1;
            end
        end
    end

    always_comb begin
        road_d = (row_hit && col_hit) ? LINE_COLOR : track_color;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_q   <= '0;
            div_cnt_q <= '0;
            level_q   <= '0;
            step_q    <= 1'b0;
            pend_q    <= '0;
            offset_q  <= '0;
            road_q    <= '0;
        end else begin
            presc_q   <= presc_d;
            div_cnt_q <= div_cnt_d;
            level_q   <= level;
            step_q    <= step_d;
            pend_q    <= pend_d;
            offset_q  <= offset_d;
            road_q    <= road_d;
        end
    end

    assign road_out   = road_q;
    assign offset     = offset_q;
    assign step_pulse = step_q;

endmodule

// File: doc/road_scroller.md
Name: road_scroller

Overview:
- Parametrised lane-marker animation engine for the racing display; successor to the fixed six-dash road block.
- Generates N vertical dashed lane lines that scroll downward at a level-dependent speed. The scroll offset is modulo-arithmetic, so there is no restart jump.
- Offset updates are applied only at frame start (tear-free).
- Takes pixel coordinates from the display timing generator and the track colour from the track block. Outputs a registered 12-bit road pixel plus the scroll offset, so sprites can stay synchronised.

Parameters:
- CLK_HZ, 100000000, system clock frequency.
- BASE_HZ, 500, base tick rate.
- DASH_LEN, 48, dash length in rows.
- DASH_GAP, 48, gap length in rows. PERIOD = DASH_LEN + DASH_GAP.
- STEP, 8, rows advanced per step. Must satisfy 1 ≤ STEP < PERIOD.
- NUM_LANES, 2, number of dashed lines (1..8).
- LANE_X0, 255, left column of lane 0.
- LANE_PITCH, 128, column spacing between lanes.
- LINE_W, 4, line width in columns.
- DIV0, 6, level-0 tick divisor.
- DIV1, 4, level-1 tick divisor.
- DIV2, 2, level-2 tick divisor.
- DIV3, 1, level-3 tick divisor.
- LINE_COLOR, 12'hFFF, dash colour.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, synchronous active-low reset.
- pix_row, in, 10, current pixel row.
- pix_col, in, 10, current pixel column.
- level, in, 2, game level.
- enable, in, 1, scroll enable (0 = paused).
- frame_start, in, 1, one-cycle pulse at start of vertical blank.
- track_color, in, 12, background colour for the current pixel.
- road_out, out, 12, registered road pixel colour.
- offset, out, clog2(PERIOD), current scroll offset.
- step_pulse, out, 1, one-cycle pulse on each speed step.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (reset_n sampled on posedge clk).
- Reset values: road_out=0, offset=0, step_pulse=0. Prescaler, divider and pending counters all 0.
- Prescaler:
  - Counts 0..CLK_HZ/BASE_HZ-1, then wraps.
  - tick is high for one cycle when the count equals its terminal value.
- Divider:
  - div = DIV[level]. On each tick: if div_cnt == div, then div_cnt←0 and step_pulse=1 the next cycle; else div_cnt increments.
  - Net effect: one step per (div+1) ticks.
  - Any change of level (compared with the registered previous level) clears div_cnt in that cycle.
- Enable:
  - enable=0: prescaler runs; div_cnt and pend are held at 0; no step_pulse; offset frozen.
- Pending accumulator:
  - pend is 4 bits and saturates at 15.
  - Incremented on each step.
- Frame-synced apply:
  - On frame_start: offset ← (offset + pend·STEP) mod PERIOD; pend←0.
  - If a step occurs in the same cycle as frame_start, that step is included: the applied count is pend+1, saturated at 15.
  - offset never changes outside frame_start cycles.
- Wrap: modulo arithmetic is exact for any pend ≤ 15, e.g. PERIOD=96, offset 88, +8 → 0.
- Pixel generation (1-cycle latency):
  - row_hit = ((pix_row + PERIOD·k − offset) mod PERIOD) < DASH_LEN. Dashes move toward larger rows as offset grows.
  - col_hit = pix_col ∈ [LANE_X0 + i·LANE_PITCH, LANE_X0 + i·LANE_PITCH + LINE_W − 1] for some i < NUM_LANES.
  - road_out(t+1) = (row_hit & col_hit) ? LINE_COLOR : track_color(t).
  - Pixel path is independent of enable.
- Reset mid-frame: all state returns to reset values on the next edge; road_out=0 for that cycle.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles mid-scroll (offset=40) → road_out=0, offset=0, step_pulse=0; first step_pulse after release no earlier than a full divider period.
- Speed: CLK_HZ=1000, BASE_HZ=100, enable=1 → level 3 gives step_pulse every 20 cycles; level 0 every 70 cycles; switching level 0→3 mid-count gives the next pulse ≤20 cycles later.
- Frame sync: 3 steps accumulated, no frame_start for 100 cycles → offset stays 0; frame_start pulse → offset=24 next cycle, pend=0. Step coincident with frame_start → offset=32.
- Wrap and saturation:
  - offset=88, pend=3 → offset=16.
  - 20 steps before frame_start → pend=15; offset 0 → (15·8) mod 96 = 24.
- Pixel with offset=0, track_color=12'h070:
  - (row 10, col 255) → FFF.
  - (10, 258) → FFF.
  - (10, 259) → 070.
  - (50, 256) → 070.
  - (10, 383) → FFF.
  - offset=8, (5, 256) → 070; (8, 256) → FFF. All one cycle after inputs.
- Pause: enable=0 for 500 cycles → no step_pulse, offset unchanged across frame_start pulses; re-enable → stepping resumes from div_cnt=0.
